// File: rtl/alu_pkg.sv
// Shared ALU opcodes, BIST FSM encoding and polynomial defaults.
// Also holds the LFSR step and the ALU golden-model helpers.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [31:0] DEF_LFSR_TAPS = 32'h00400007;
  localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SAMPLE, ST_DONE} bist_state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l, input logic [31:0] taps);
    return {l[30:0], 1'b0} ^ (l[31] ? taps : 32'h0);
  endfunction

  // Op index within a vector -> opcode, in the fixed AND/OR/ADD/SUB order.
  function automatic logic [3:0] op_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return ALU_AND;
      2'd1:    return ALU_OR;
      2'd2:    return ALU_ADD;
      default: return ALU_SUB;
    endcase
  endfunction

  function automatic logic [31:0] alu_golden(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      default: return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/alu_bist_if.sv
// Combinational ALU operand/result bus between the BIST initiator and the ALU.
interface alu_bist_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;

  modport master (output alu_a, alu_b, alu_op, input alu_result);
  modport slave  (input alu_a, alu_b, alu_op, output alu_result);
endinterface

// File: rtl/alu_bist_lfsr.sv
// Seedable 32-bit Galois LFSR; o_next is the state one step ahead.
module alu_bist_lfsr
  import alu_pkg::*;
#(
  parameter logic [31:0] TAPS = DEF_LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_seed,
  input  logic        i_step,
  output logic [31:0] o_state,
  output logic [31:0] o_next
);
  logic [31:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_state <= '0;
    else if (i_load) r_state <= i_seed;
    else if (i_step) r_state <= lfsr_step(r_state, TAPS);
  end

  assign o_state = r_state;
  assign o_next  = lfsr_step(r_state, TAPS);
endmodule

// File: rtl/alu_bist.sv
// ALU BIST initiator: walks LFSR operand pairs through AND/OR/ADD/SUB,
// checks each result against the golden model and folds it into a MISR.
module alu_bist
  import alu_pkg::*;
#(
  parameter int          N_VECTORS = 16,
  parameter logic [31:0] SEED      = 32'h00000001,
  parameter logic [31:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [31:0] MISR_POLY = DEF_MISR_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  alu_bist_if.master  bus,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] signature,
  output logic [15:0] fail_vec,
  output logic [3:0]  fail_op,
  output logic        fail_valid
);
  bist_state_e r_state;
  logic [31:0] r_alu_a, r_alu_b, r_sig;
  logic [3:0]  r_alu_op, r_fail_op;
  logic [15:0] r_vec, r_err, r_fail_vec;
  logic [1:0]  r_opi;
  logic        r_busy, r_done, r_pass, r_fail_valid;

  logic [31:0] w_lfsr, w_lfsr_next, w_golden, w_sig_next;
  logic [15:0] w_err_next;
  logic        w_mis, w_last, w_start, w_step;

  assign w_start  = start && (r_state == ST_IDLE || r_state == ST_DONE);
  // Two LFSR steps per vector, taken during ops 0/1, leave it at the next a.
  assign w_step   = (r_state == ST_SAMPLE) && (r_opi == 2'd0 || r_opi == 2'd1);
  assign w_golden = alu_golden(r_alu_a, r_alu_b, r_alu_op);
  assign w_mis    = bus.alu_result != w_golden;
  assign w_err_next = (w_mis && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;
  assign w_sig_next = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? MISR_POLY : 32'h0) ^ bus.alu_result;
  assign w_last   = (r_opi == 2'd3) && (r_vec == 16'(N_VECTORS - 1));

  alu_bist_lfsr #(.TAPS(LFSR_TAPS)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_start),
    .i_seed  (SEED),
    .i_step  (w_step),
    .o_state (w_lfsr),
    .o_next  (w_lfsr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_sig        <= '0;
      r_err        <= '0;
      r_vec        <= '0;
      r_opi        <= '0;
      r_fail_vec   <= '0;
      r_fail_op    <= '0;
      r_fail_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start) begin
          r_state      <= ST_APPLY;
          r_alu_a      <= SEED;
          r_alu_b      <= lfsr_step(SEED, LFSR_TAPS);
          r_alu_op     <= ALU_AND;
          r_sig        <= '0;
          r_err        <= '0;
          r_vec        <= '0;
          r_opi        <= '0;
          r_fail_vec   <= '0;
          r_fail_op    <= '0;
          r_fail_valid <= 1'b0;
          r_busy       <= 1'b1;
          r_done       <= 1'b0;
          r_pass       <= 1'b0;
        end
        ST_APPLY: r_state <= ST_SAMPLE;
        ST_SAMPLE: begin
          r_err <= w_err_next;
          r_sig <= w_sig_next;
          if (w_mis && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_vec   <= r_vec;
            r_fail_op    <= r_alu_op;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 16'd0);
          end else begin
            r_state <= ST_APPLY;
            if (r_opi == 2'd3) begin
              r_vec    <= r_vec + 16'd1;
              r_opi    <= 2'd0;
              r_alu_op <= ALU_AND;
              r_alu_a  <= w_lfsr;
              r_alu_b  <= w_lfsr_next;
            end else begin
              r_opi    <= r_opi + 2'd1;
              r_alu_op <= op_of(r_opi + 2'd1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_a  = r_alu_a;
  assign bus.alu_b  = r_alu_b;
  assign bus.alu_op = r_alu_op;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign signature  = r_sig;
  assign fail_vec   = r_fail_vec;
  assign fail_op    = r_fail_op;
  assign fail_valid = r_fail_valid;
endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
Built-in self-test initiator for the ALU: drives operand/opcode vectors onto the ALU's combinational a/b/op interface, samples its result, checks it against an internal golden model, and compresses all results into a signature.
Sits beside the datapath ALU, selected in for test mode by the top level.
Reports pass/fail, error count, first-failure info and a MISR signature for comparison against a known-good value.

Parameters:
N_VECTORS, 16, number of operand pairs; legal range 1..65535; each pair is run through all 4 ops.
SEED, 32'h00000001, LFSR seed; must be nonzero.
LFSR_TAPS, 32'h00400007, Galois feedback mask (x^32+x^22+x^2+x+1).
MISR_POLY, 32'h04C11DB7, signature feedback mask.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse; begins a run.
alu_a  out  32  operand A to ALU.
alu_b  out  32  operand B to ALU.
alu_op  out  4  opcode to ALU.
alu_result  in  32  ALU combinational result.
busy  out  1  run in progress.
done  out  1  run complete; held until next start or reset.
pass  out  1  done and err_count==0.
err_count  out  16  mismatches; saturates at 16'hFFFF.
signature  out  32  MISR value.
fail_vec  out  16  vector index of first mismatch.
fail_op  out  4  opcode of first mismatch.
fail_valid  out  1  a first mismatch has been captured.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including alu_a/b/op, counters and LFSR (LFSR loads SEED on start).
- Op sequence per vector, fixed order: 4'b0000 AND, 4'b0001 OR, 4'b0010 ADD, 4'b0110 SUB.
- Golden model:
  - AND: a&b.
  - OR: a|b.
  - ADD: (a+b) mod 2^32.
  - SUB: (a-b) mod 2^32, two's complement; no overflow flag.
- LFSR step: next = {l[30:0],1'b0} ^ (l[31] ? LFSR_TAPS : 0).
  - Per vector: a = current LFSR value, b = LFSR stepped once; LFSR then stepped again for the next vector.
  - Vector 0 therefore uses a=SEED, b=step(SEED).
- FSM states: IDLE, APPLY, SAMPLE, DONE.
  - IDLE/DONE + start: clear err_count, signature, fail_*, done; load LFSR with SEED; drive vector 0/op AND registered; go to APPLY; busy=1.
  - APPLY: outputs stable for one full cycle (ALU settles); go to SAMPLE.
  - SAMPLE: at the edge ending SAMPLE, capture alu_result and compare with the golden model.
    - Mismatch: err_count++ (saturating). If fail_valid=0, latch fail_vec, fail_op and set fail_valid.
    - Always update the signature: sig = ((sig<<1) ^ (sig[31] ? MISR_POLY : 0)) ^ alu_result.
    - If not the last op: drive the next op (or next vector, op AND) and go to APPLY.
    - Else: go to DONE; busy=0, done=1.
  - DONE: alu_a/b/op hold their last values; pass = (err_count==0).
- Latency: 2 cycles per op, 8 per vector. done rises exactly 8*N_VECTORS rising edges after the edge that samples start.
- start while busy: ignored, no restart.
- start in DONE: clean restart; done drops on the next edge.
- Reset mid-run: immediate return to IDLE with all outputs 0. No partial results are retained.
- pass is never 1 while busy.

Decomposition:
- Shared package alu_pkg, holding:
  - ALU opcode constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110.
  - FSM state encoding.
  - LFSR_TAPS and MISR_POLY defaults.
- One natural sub-module: alu_bist_lfsr (seedable 32-bit Galois LFSR with load/step controls).
- The golden model and MISR stay inline.

Test Plan:
- Good ALU, N_VECTORS=1, SEED=1 -> vector a=1, b=2; results 0, 3, 3, 32'hFFFFFFFF; done at edge 8 after start; err_count=0; pass=1; signature=32'hFFFFFFF5.
- Good ALU, N_VECTORS=16 -> done at edge 128; pass=1; fail_valid=0; signature matches the bench reference model.
- Faulty ALU (SUB result bit0 inverted), N_VECTORS=4 -> err_count=4; fail_valid=1; fail_vec=0; fail_op=4'b0110; pass=0.
- start re-pulsed at cycles 3 and 5 of a run -> ignored; done still at edge 8*N_VECTORS; a start after done restarts with identical signature.
- rst_n low mid-run (cycle 10, N=4) -> all outputs 0 asynchronously; after release and start, full run completes with correct pass/signature.
- Stuck-at-0 result, N_VECTORS=1 -> err_count=3 (AND matches); fail_op=4'b0001; signature=0.
